// File: rtl/fighter_if.sv
// fighter_if: frame-tick and controller inputs plus sprite placement outputs of one fighter.
// Ports: frame_tick, buttons (active-low) in; char_x, char_y, anim_row, anim_col, facing_right, airborne out.
// master = controller/top side, slave = fighter_sequencer side.
interface fighter_if;
  logic       frame_tick;
  logic [7:0] buttons;
  logic [9:0] char_x;
  logic [9:0] char_y;
  logic [9:0] anim_row;
  logic [9:0] anim_col;
  logic       facing_right;
  logic       airborne;

  modport master (
    output frame_tick, buttons,
    input  char_x, char_y, anim_row, anim_col, facing_right, airborne
  );

  modport slave (
    input  frame_tick, buttons,
    output char_x, char_y, anim_row, anim_col, facing_right, airborne
  );
endinterface

// File: rtl/fighter_sequencer.sv
// fighter_sequencer: per-fighter motion/animation FSM (IDLE, WALK, JUMP, FALL) advanced once per frame tick.
// Ports: clk, rst_n (sync, active-low), bus (fighter_if.slave): buttons/frame_tick in, sprite origin/frame out.
// Latency: outputs registered, update on the clk edge that samples frame_tick=1; no backpressure, every tick is consumed.
module fighter_sequencer #(
  parameter int X_INIT    = 100,
  parameter int X_MAX     = 594,
  parameter int Y_FLOOR   = 420,
  parameter int WALK_STEP = 5,
  parameter int JUMP_VEL  = 12,
  parameter int GRAVITY   = 1,
  parameter int MAX_FALL  = 12,
  parameter int ANIM_DIV  = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  fighter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WALK, JUMP, FALL} state_t;

  localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  // All motion arithmetic is done in 11-bit signed so clamps see the true
  // result instead of a wrapped 10-bit value.
  localparam logic signed [10:0] STEP_S  = 11'(WALK_STEP);
  localparam logic signed [10:0] XMAX_S  = 11'(X_MAX);
  localparam logic signed [10:0] FLOOR_S = 11'(Y_FLOOR);
  localparam logic signed [10:0] JVEL_S  = 11'(JUMP_VEL);
  localparam logic signed [10:0] GRAV_S  = 11'(GRAVITY);
  localparam logic signed [10:0] MFALL_S = 11'(MAX_FALL);
  localparam logic [DW-1:0]      DIV_TOP = DW'(ANIM_DIV - 1);

  state_t            state, state_nx;
  logic [9:0]        x_q, x_nx;
  logic [9:0]        y_q, y_nx;
  logic signed [10:0] vy_q, vy_nx;
  logic [2:0]        f_q, f_nx;
  logic [DW-1:0]     div_q, div_nx;
  logic              face_q, face_nx;
  logic              jprev_q, jprev_nx;
  logic [9:0]        row_q, row_nx;
  logic [9:0]        col_q, col_nx;
  logic              air_q, air_nx;

  logic right, left, jump, one_dir, jump_edge;
  logic signed [10:0] xs, ys, xt, yt, vt;
  logic unused_buttons;

  assign right     = ~bus.buttons[0];
  assign left      = ~bus.buttons[1];
  assign jump      = ~bus.buttons[3];
  assign one_dir   = right ^ left;
  assign jump_edge = jump & ~jprev_q;
  assign unused_buttons = ^{bus.buttons[7:4], bus.buttons[2]};

  assign xs = $signed({1'b0, x_q});
  assign ys = $signed({1'b0, y_q});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      x_q     <= 10'(X_INIT);
      y_q     <= 10'(Y_FLOOR);
      vy_q    <= '0;
      f_q     <= '0;
      div_q   <= '0;
      face_q  <= 1'b1;
      jprev_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      air_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      x_q     <= x_nx;
      y_q     <= y_nx;
      vy_q    <= vy_nx;
      f_q     <= f_nx;
      div_q   <= div_nx;
      face_q  <= face_nx;
      jprev_q <= jprev_nx;
      row_q   <= row_nx;
      col_q   <= col_nx;
      air_q   <= air_nx;
    end
  end

  always_comb begin
    state_nx = state;
    x_nx     = x_q;
    y_nx     = y_q;
    vy_nx    = vy_q;
    f_nx     = f_q;
    div_nx   = div_q;
    face_nx  = face_q;
    jprev_nx = jprev_q;
    row_nx   = row_q;
    col_nx   = col_q;
    air_nx   = air_q;
    xt       = '0;
    yt       = '0;
    vt       = '0;

    if (bus.frame_tick) begin
      jprev_nx = jump;

      // Horizontal motion applies in every state, including mid-air.
      if (right && !left) begin
        xt      = xs + STEP_S;
        x_nx    = (xt > XMAX_S) ? XMAX_S[9:0] : xt[9:0];
        face_nx = 1'b1;
      end else if (left && !right) begin
        xt      = xs - STEP_S;
        x_nx    = (xt < 11'sd0) ? 10'd0 : xt[9:0];
        face_nx = 1'b0;
      end

      case (state)
        IDLE, WALK: begin
          if (jump_edge) begin
            state_nx = JUMP;
            vy_nx    = JVEL_S;
          end else if (one_dir) begin
            state_nx = WALK;
          end else begin
            state_nx = IDLE;
          end
        end
        JUMP: begin
          yt = ys - vy_q;
          vt = vy_q - GRAV_S;
          if (yt < 11'sd0) begin
            // Ceiling hit: stop rising immediately.
            y_nx     = 10'd0;
            vy_nx    = '0;
            state_nx = FALL;
          end else begin
            y_nx  = yt[9:0];
            vy_nx = vt;
            if (vt <= 11'sd0) state_nx = FALL;
          end
        end
        FALL: begin
          vt = vy_q + GRAV_S;
          if (vt > MFALL_S) vt = MFALL_S;
          yt = ys + vt;
          if (yt >= FLOOR_S) begin
            y_nx     = FLOOR_S[9:0];
            vy_nx    = '0;
            state_nx = one_dir ? WALK : IDLE;
          end else begin
            y_nx  = yt[9:0];
            vy_nx = vt;
          end
        end
        default: state_nx = IDLE;
      endcase

      // Animation frame follows the state being entered on this tick.
      case (state_nx)
        WALK: begin
          if (state != WALK) begin
            f_nx   = 3'd0;
            div_nx = '0;
          end else if (div_q == DIV_TOP) begin
            div_nx = '0;
            f_nx   = (f_q == 3'd5) ? 3'd0 : f_q + 3'd1;
          end else begin
            div_nx = div_q + DW'(1);
          end
        end
        JUMP: begin
          f_nx   = 3'd3;
          div_nx = '0;
        end
        FALL: begin
          f_nx   = 3'd4;
          div_nx = '0;
        end
        default: begin
          f_nx   = 3'd0;
          div_nx = '0;
        end
      endcase

      // Sheet offsets are registered alongside the frame index so the ROM
      // address generator sees plain flop outputs.
      row_nx = (f_nx >= 3'd3) ? 10'd30 : 10'd0;
      case (f_nx)
        3'd1, 3'd4: col_nx = 10'd23;
        3'd2, 3'd5: col_nx = 10'd46;
        default:    col_nx = 10'd0;
      endcase
      air_nx = (state_nx == JUMP) || (state_nx == FALL);
    end
  end

  assign bus.char_x       = x_q;
  assign bus.char_y       = y_q;
  assign bus.anim_row     = row_q;
  assign bus.anim_col     = col_q;
  assign bus.facing_right = face_q;
  assign bus.airborne     = air_q;

endmodule

// File: tb/tb_fighter_sequencer.sv
// tb_fighter_sequencer: directed bench for fighter_sequencer with hand-computed expectations.
// Ports: none; instantiates fighter_if and the DUT, drives one tick per two clk.
// Outputs are sampled on the falling edge after each tick.
module tb_fighter_sequencer;

  localparam logic [7:0] B_NONE  = 8'hFF;
  localparam logic [7:0] B_RIGHT = 8'hFE;
  localparam logic [7:0] B_LEFT  = 8'hFD;
  localparam logic [7:0] B_BOTH  = 8'hFC;
  localparam logic [7:0] B_JUMP  = 8'hF7;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   air_cnt;

  fighter_if bus ();

  fighter_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame tick with the given buttons; returns on the following falling edge.
  task automatic tick(input logic [7:0] b);
    bus.buttons    = b;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic ticks(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) tick(b);
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst_n          = 1'b0;
    bus.frame_tick = 1'b0;
    bus.buttons    = B_RIGHT;

    // Reset held two clocks with frame_tick high: reset must win.
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.frame_tick = 1'b0;
    rst_n          = 1'b1;
    check("rst_x",    bus.char_x, 100);
    check("rst_y",    bus.char_y, 420);
    check("rst_face", bus.facing_right, 1);
    check("rst_row",  bus.anim_row, 0);
    check("rst_col",  bus.anim_col, 0);
    check("rst_air",  bus.airborne, 0);

    // Walk right: tick 1 enters WALK, frame advances every 8 ticks after that.
    ticks(B_RIGHT, 3);
    check("walk_x3",    bus.char_x, 115);
    check("walk_face",  bus.facing_right, 1);
    ticks(B_RIGHT, 5);
    check("walk_col_t8", bus.anim_col, 0);
    tick(B_RIGHT);
    check("walk_col_t9", bus.anim_col, 23);
    check("walk_row_t9", bus.anim_row, 0);
    ticks(B_RIGHT, 39);
    check("walk_row_t48", bus.anim_row, 30);
    check("walk_col_t48", bus.anim_col, 46);
    tick(B_RIGHT);
    check("walk_row_wrap", bus.anim_row, 0);
    check("walk_col_wrap", bus.anim_col, 0);
    check("walk_x_t49",    bus.char_x, 345);

    // Right-edge clamp.
    ticks(B_RIGHT, 49);
    check("clamp_x590", bus.char_x, 590);
    tick(B_RIGHT);
    check("clamp_r1", bus.char_x, 594);
    tick(B_RIGHT);
    check("clamp_r2", bus.char_x, 594);

    // Left-edge clamp: 594 - 118*5 = 4, then max(4-5,0) = 0.
    ticks(B_LEFT, 118);
    check("left_x4",   bus.char_x, 4);
    tick(B_LEFT);
    check("left_x0",   bus.char_x, 0);
    check("left_face", bus.facing_right, 0);
    tick(B_RIGHT);
    check("right_x5",  bus.char_x, 5);
    tick(B_BOTH);
    check("both_x",    bus.char_x, 5);
    check("both_face", bus.facing_right, 1);
    check("both_idle_col", bus.anim_col, 0);

    // Jump arc from IDLE: rise 12+11+..+1 = 78 px, then fall back in 12 ticks.
    tick(B_NONE);
    tick(B_JUMP);
    check("jump_air",  bus.airborne, 1);
    check("jump_y0",   bus.char_y, 420);
    check("jump_row",  bus.anim_row, 30);
    check("jump_col",  bus.anim_col, 0);
    ticks(B_NONE, 11);
    check("jump_y343", bus.char_y, 343);
    check("jump_col11", bus.anim_col, 0);
    tick(B_NONE);
    check("apex_y342", bus.char_y, 342);
    check("fall_row",  bus.anim_row, 30);
    check("fall_col",  bus.anim_col, 23);
    ticks(B_NONE, 11);
    check("fall_y408", bus.char_y, 408);
    check("fall_air",  bus.airborne, 1);
    tick(B_NONE);
    check("land_y",    bus.char_y, 420);
    check("land_air",  bus.airborne, 0);
    check("land_row",  bus.anim_row, 0);
    check("land_col",  bus.anim_col, 0);
    check("land_x",    bus.char_x, 5);

    // Jump held 40 ticks: exactly one 24-tick airborne arc.
    air_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick(B_JUMP);
      if (bus.airborne === 1'b1) air_cnt++;
    end
    check("held_air_ticks", air_cnt, 24);
    check("held_air_end",   bus.airborne, 0);
    check("held_y_end",     bus.char_y, 420);
    tick(B_NONE);
    tick(B_JUMP);
    check("rejump_air", bus.airborne, 1);

    // Reset during FALL: y = 342 + 8*9/2 = 378 after 8 fall ticks.
    ticks(B_NONE, 12);
    ticks(B_NONE, 8);
    check("mid_fall_y",   bus.char_y, 378);
    check("mid_fall_col", bus.anim_col, 23);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_y",   bus.char_y, 420);
    check("midrst_air", bus.airborne, 0);
    check("midrst_x",   bus.char_x, 100);
    check("midrst_row", bus.anim_row, 0);

    // No frame tick: buttons must be ignored.
    bus.buttons = B_RIGHT;
    repeat (100) @(negedge clk);
    check("notick_x",    bus.char_x, 100);
    check("notick_y",    bus.char_y, 420);
    check("notick_face", bus.facing_right, 1);
    tick(B_LEFT);
    check("after_x",    bus.char_x, 95);
    check("after_face", bus.facing_right, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
